tail_light_seq: RTL
===================

Name: tail_light_seq

Overview:
- Parametrised successor to the fixed 8-LED tail light controller.
- Drives a 2N-LED bar: left half and right half, each with N LEDs.
- Produces sequential "fill-outward" turn indications, a hazard flash when both requests are active, and a step-rate prescaler.
- Sits between the turn/hazard switch inputs and the LED driver outputs.

Parameters:
- LEDS_PER_SIDE, 4, N: LEDs per half. Legal range is N ≥ 2. LEDS width is 2N.
- STEP_DIV, 1, clock cycles per sequence step. Legal range is ≥ 1. A value of 1 means one step per clock.
- DIV_W, 16, prescaler counter width. Requires STEP_DIV ≤ 2^DIV_W.

Ports:
- clk, input, 1, rising-edge clock.
- reset, input, 1, asynchronous, active-low reset. One clock domain only.
- left, input, 1, left turn request. Level-sensitive, sampled on clk.
- right, input, 1, right turn request. Level-sensitive, sampled on clk.
- brake, input, 1, brake request. Only used when TAIL_BRAKE_EN is defined; otherwise ignored.
- LEDS, output, 2N, registered lamp outputs. LEDS[2N-1:N] is the left half, with LEDS[N] innermost. LEDS[N-1:0] is the right half, with LEDS[N-1] innermost.
- active, output, 1, registered. High whenever the state is not IDLE.

Behaviour:
- Reset (reset=0), applied asynchronously at any time, including mid-sequence:
  - state is IDLE, step = 0, prescaler = 0.
  - LEDS = 0 and active = 0 immediately.
- States: IDLE, LEFT_RUN, RIGHT_RUN, HAZARD.
- Step counter: range 0..N.
- Prescaler: counts 0..STEP_DIV-1. tick = (prescaler == STEP_DIV-1).
- Request decode, evaluated in IDLE and at frame boundaries:
  - left & right → HAZARD
  - left only → LEFT_RUN
  - right only → RIGHT_RUN
  - neither → IDLE
- Leaving IDLE: on the first edge where decode ≠ IDLE, the target state is entered with step = 1 and prescaler = 0. LEDS shows step 1 on that same edge, i.e. one cycle of latency from the sampled request.
- RUN and HAZARD states:
  - On a tick with step < N: step increments.
  - On a tick with step = N: step becomes 0 (the off frame).
  - On a tick with step = 0 (frame boundary): re-decode the requests. Same or different active request → that state with step = 1. No request → IDLE.
- Requests are ignored between frame boundaries. A sequence that has started always completes, including the off frame.
  - A single-cycle pulse therefore yields one full frame.
  - Changing between left, right and both mid-frame takes effect only at the next boundary.
- Each step lasts exactly STEP_DIV cycles. One frame lasts (N+1)·STEP_DIV cycles.
- LEDS patterns:
  - LEFT_RUN: the `step` innermost left LEDs are lit (LEDS[N .. N+step-1]). The right half is 0.
  - RIGHT_RUN: LEDS[N-1 .. N-step] are lit. The left half is 0.
  - HAZARD: all 2N LEDs are lit when step ≠ 0, and all are 0 when step = 0.
  - IDLE: 0.
- LEDS and active are registered and computed from the next state and next step. There are no combinational paths from inputs to outputs.

Optional Feature:
- Macro: TAIL_BRAKE_EN.
- When defined:
  - brake=1 forces every half that is not currently sequencing to all-ones. In IDLE both halves are on.
  - In LEFT_RUN the right half is all-ones; in RIGHT_RUN the left half is all-ones.
  - In HAZARD, brake is ignored (hazard has priority).
  - The overlay is registered (1-cycle latency) and does not alter state, step or active.
- When undefined: the brake port is unused and the outputs are identical to a build with brake tied to 0.

Test Plan:
- Reset handling: N=4, STEP_DIV=1. Assert reset=0 mid-LEFT_RUN at step 2 → LEDS = 8'h00 and active = 0 immediately, without waiting for a clock. Release reset with no requests → stays IDLE.
- Left pulse: left=1 for 1 cycle → LEDS on successive edges: 10h, 30h, 70h, F0h, 00h, then IDLE (active falls on the 6th edge).
- Right held: right held for 12 cycles → repeating 08h, 0Ch, 0Eh, 0Fh, 00h. Release right mid-frame → the frame completes to 00h, then IDLE.
- Hazard and mode switch: left=right=1 → FFh ×4 cycles, then 00h ×1, repeating. Drop to left only mid-frame → the hazard frame finishes, then the next frame starts with 10h.
- Prescaler: STEP_DIV=3 → each pattern is held exactly 3 cycles; a frame is 15 cycles.
- Brake overlay (TAIL_BRAKE_EN): brake=1 in IDLE → LEDS = FFh after 1 cycle. brake=1 during LEFT_RUN step 2 → LEDS = 3Fh. brake during HAZARD off frame → 00h.

Source files
------------

// File: rtl/tail_light_seq.sv
// tail_light_seq: sequential "fill-outward" turn indicator for a 2N-LED bar.
// The left half fills from LEDS[N] upward and the right half fills from
// LEDS[N-1] downward. Both requests together give a hazard flash. A
// prescaler sets how long each step lasts.
// Optional feature: define TAIL_BRAKE_EN to enable the brake overlay. With
// it, brake lights every half that is not sequencing.
module tail_light_seq #(
    parameter int LEDS_PER_SIDE = 4,
    parameter int STEP_DIV      = 1,
    parameter int DIV_W         = 16
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         left,
    input  logic                         right,
    input  logic                         brake,
    output logic [2*LEDS_PER_SIDE-1:0]   LEDS,
    output logic                         active
);

    localparam int N      = LEDS_PER_SIDE;
    localparam int STEP_W = $clog2(N + 1);

    localparam logic [STEP_W-1:0] STEP_ZERO = '0;
    localparam logic [STEP_W-1:0] STEP_ONE  = STEP_W'(1);
    localparam logic [STEP_W-1:0] STEP_LAST = STEP_W'(N);
    localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(STEP_DIV - 1);
    localparam logic [DIV_W-1:0]  DIV_ONE   = DIV_W'(1);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        LEFT_RUN  = 2'd1,
        RIGHT_RUN = 2'd2,
        HAZARD    = 2'd3
    } state_t;

    state_t               state_q, state_d;
    logic [STEP_W-1:0]    step_q,  step_d;
    logic [DIV_W-1:0]     div_q,   div_d;
    logic [2*N-1:0]       leds_q,  leds_d;
    logic                 active_q, active_d;
    logic                 tick;
    state_t               req_state;

    // Map the raw switch levels to the sequence they ask for.
    function automatic state_t decode_req(input logic l, input logic r);
        case ({l, r})
            2'b11:   decode_req = HAZARD;
            2'b10:   decode_req = LEFT_RUN;
            2'b01:   decode_req = RIGHT_RUN;
            default: decode_req = IDLE;
        endcase
    endfunction

    // Bit i is lit when i < s: bit 0 is the innermost LED of a half.
    function automatic logic [N-1:0] fill_mask(input logic [STEP_W-1:0] s);
        for (int i = 0; i < N; i++) begin
            fill_mask[i] = (i < int'(s));
        end
    endfunction

    // The right half grows downward, so its innermost LED is the top bit.
    function automatic logic [N-1:0] reverse_bits(input logic [N-1:0] v);
        for (int i = 0; i < N; i++) begin
            reverse_bits[i] = v[N-1-i];
        end
    endfunction

    assign tick      = (div_q == DIV_LAST);
    assign req_state = decode_req(left, right);

    // Next state, step and prescaler; requests only matter in IDLE and at step 0.
    always_comb begin
        state_d = state_q;
        step_d  = step_q;
        div_d   = div_q;
        if (state_q == IDLE) begin
            div_d = '0;
            if (req_state != IDLE) begin
                state_d = req_state;
                step_d  = STEP_ONE;
            end
        end else begin
            div_d = tick ? '0 : (div_q + DIV_ONE);
            if (tick) begin
                if (step_q == STEP_ZERO) begin
                    state_d = req_state;
                    step_d  = (req_state == IDLE) ? STEP_ZERO : STEP_ONE;
                end else if (step_q == STEP_LAST) begin
                    step_d = STEP_ZERO;
                end else begin
                    step_d = step_q + STEP_ONE;
                end
            end
        end
    end

    // Lamp pattern from the next state/step, so outputs line up with the state flops.
    always_comb begin
        leds_d   = '0;
        active_d = (state_d != IDLE);
        case (state_d)
            LEFT_RUN:  leds_d[2*N-1:N] = fill_mask(step_d);
            RIGHT_RUN: leds_d[N-1:0]   = reverse_bits(fill_mask(step_d));
            HAZARD:    leds_d          = (step_d != STEP_ZERO) ? '1 : '0;
            default:   leds_d          = '0;
        endcase
`ifdef TAIL_BRAKE_EN
        if (brake) begin
            case (state_d)
                IDLE:      leds_d          = '1;
                LEFT_RUN:  leds_d[N-1:0]   = '1;
                RIGHT_RUN: leds_d[2*N-1:N] = '1;
                default:   leds_d          = leds_d;
            endcase
        end
`endif
    end

`ifndef TAIL_BRAKE_EN
    logic unused_brake;
    assign unused_brake = brake;
`endif

    // State and output registers, cleared asynchronously.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            step_q   <= '0;
            div_q    <= '0;
            leds_q   <= '0;
            active_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            step_q   <= step_d;
            div_q    <= div_d;
            leds_q   <= leds_d;
            active_q <= active_d;
        end
    end

    assign LEDS   = leds_q;
    assign active = active_q;

endmodule
